tape_stream_reader: RTL and testbench
=====================================

Name: tape_stream_reader

Overview:
- Initiator for the SDRAM tape read channel (tape_addr / tape_rd / tape_dout / tape_rd_ack toggle handshake).
- Fetches a contiguous byte range from SDRAM, one outstanding request at a time, into a small FIFO.
- Presents the bytes to the tape playback logic over a valid/ready byte stream.
- Sits between the SDRAM controller (or its simulation model) and the CDT/tape bit generator.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of 2, minimum 2.
- ADDR_W, 23, SDRAM byte address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin fetch; ignored unless idle
- stop  in  1  one-cycle pulse: abort fetch and flush FIFO
- start_addr  in  ADDR_W  first byte address, sampled on start
- tape_len  in  ADDR_W  number of bytes to fetch, sampled on start
- tape_addr  out  ADDR_W  SDRAM read address
- tape_rd  out  1  read request strobe, one cycle per byte
- tape_dout  in  8  read data, valid in the cycle tape_rd_ack toggles
- tape_rd_ack  in  1  toggles once per completed read
- byte_data  out  8  FIFO head byte
- byte_valid  out  1  FIFO not empty
- byte_ready  in  1  consumer accepts byte_data when byte_valid is high
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  all tape_len bytes fetched and FIFO empty
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values:
  - state IDLE; tape_addr 0; tape_rd 0; FIFO empty.
  - byte_valid 0; byte_data 0; busy 0; done 0; fifo_level 0.
  - remaining 0; ack_seen captures tape_rd_ack.
- Request protocol: tape_rd is high for exactly one cycle per byte and tape_addr is stable from that cycle until the matching ack. A request completes in the first cycle where tape_rd_ack != ack_seen; in that cycle tape_dout is captured and ack_seen <= tape_rd_ack. Never more than one request outstanding.
- ack_seen tracks tape_rd_ack every cycle while in IDLE or DONE. This resynchronises after reset, because the responder's ack is not reset.
- IDLE:
  - On start: tape_addr <= start_addr; remaining <= tape_len; done <= 0.
  - Next state is DONE if tape_len == 0, else REQ.
- REQ:
  - If fifo_level < FIFO_DEPTH: assert tape_rd, go to WAIT.
  - Otherwise hold in REQ, tape_rd low.
- WAIT: on ack, push tape_dout; tape_addr <= tape_addr + 1 (wraps mod 2^ADDR_W); remaining <= remaining - 1. Next state is DONE if remaining was 1, else REQ.
- DONE:
  - done = 1 while the FIFO is empty. busy = 0.
  - start is accepted as in IDLE.
- stop in REQ, IDLE or DONE: flush FIFO, go to IDLE.
- stop in WAIT:
  - Flush FIFO and go to ABORT.
  - ABORT waits for the pending ack, discards its data, then goes to IDLE.
  - busy stays 1 in ABORT.
- stop takes priority over start in the same cycle.
- FIFO:
  - Push and pop in the same cycle leaves fifo_level unchanged.
  - Pop when empty has no effect.
  - byte_data is the registered head entry; it is valid one cycle after the push.
- Latency with a zero-wait responder:
  - start at cycle N; tape_rd at N+1; ack seen and byte pushed at N+2; byte_valid at N+3.
  - Sustained throughput is 1 byte per 2 cycles.
- start while busy is ignored; tape_len and start_addr are not resampled.
- A synchronous reset mid-transfer returns to IDLE at once. A late ack is absorbed by the IDLE resync of ack_seen.

Test Plan:
- start_addr=0x000100, tape_len=4, RAM[0x100..0x103]=11,22,33,44, byte_ready=1 → tape_rd pulses with tape_addr 0x100..0x103; bytes 11,22,33,44 out in order; done=1 after the last pop; tape_rd pulses exactly 4.
- tape_len=12, FIFO_DEPTH=8, byte_ready=0 → exactly 8 requests issued, fifo_level=8, REQ holds. Raise byte_ready → remaining 4 bytes fetched; 12 bytes delivered in order.
- start_addr=0x7FFFFE, tape_len=4 → tape_addr sequence 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
- stop while in WAIT with the responder delaying ack 5 cycles → FIFO flushed, busy=1 until the ack arrives, then IDLE; a new start fetches correct data with no stale byte.
- tape_len=0 → no tape_rd; done=1 two cycles after start; byte_valid stays 0.
- Reset asserted mid-transfer with tape_rd_ack at an arbitrary level, then start tape_len=2 → exactly 2 requests, 2 correct bytes, no spurious push.

Source files
------------

// File: rtl/tape_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tape_stream_reader
// Description : Fetches a contiguous byte range from SDRAM over the tape read
//               channel and buffers it in a small FIFO. Bytes are presented
//               to the tape playback logic on a valid/ready byte stream.
//               Only one SDRAM request is outstanding at a time.
//
// Ports       :
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        one-cycle pulse, begin a fetch (accepted in IDLE/DONE only)
//   stop         one-cycle pulse, abort the fetch and flush the FIFO
//   start_addr   first byte address, sampled on an accepted start
//   tape_len     number of bytes to fetch, sampled on an accepted start
//   tape_addr    SDRAM read address, stable from request until its ack
//   tape_rd      read request strobe, one cycle per byte
//   tape_dout    read data, valid in the cycle tape_rd_ack toggles
//   tape_rd_ack  toggles once per completed read
//   byte_data    FIFO head byte (registered)
//   byte_valid   FIFO not empty
//   byte_ready   consumer accepts byte_data when byte_valid is high
//   busy         high in REQ, WAIT and ABORT
//   done         all bytes fetched and the FIFO drained
//   fifo_level   current FIFO occupancy
//
// Parameters  :
//   FIFO_DEPTH   byte FIFO entries, power of two, minimum 2
//   ADDR_W       SDRAM byte address width
//
// Revision    : 1.0 - initial release
// ============================================================================
module tape_stream_reader #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 23
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic [ADDR_W-1:0]           start_addr,
    input  logic [ADDR_W-1:0]           tape_len,
    output logic [ADDR_W-1:0]           tape_addr,
    output logic                        tape_rd,
    input  logic [7:0]                  tape_dout,
    input  logic                        tape_rd_ack,
    output logic [7:0]                  byte_data,
    output logic                        byte_valid,
    input  logic                        byte_ready,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_REQ   = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ABORT = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_tape_addr;
    logic [ADDR_W-1:0]  r_remaining;
    logic               r_ack_seen;
    logic               r_done;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [7:0]         r_head;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_ack;
    logic               w_can_req;
    logic               w_push;
    logic               w_pop;
    logic               w_head_from_input;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;

    // A request completes when the toggle-style ack differs from the last
    // level we recorded.
    assign w_ack     = (tape_rd_ack != r_ack_seen);
    assign w_can_req = (r_count < c_DEPTH);

    // Data of a completing read is dropped when stop arrives in the same
    // cycle, since the FIFO is being flushed anyway.
    assign w_push = (r_state == c_ST_WAIT) && w_ack && !stop;
    assign w_pop  = byte_ready && (r_count != '0);

    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_PTR_W'(1)) : r_rd_ptr;

    // The pushed byte becomes the new head when the FIFO is empty after any
    // pop of this cycle; otherwise the head comes from storage.
    assign w_head_from_input = w_push &&
                               ((r_count == '0) ||
                                ((r_count == c_CNT_W'(1)) && w_pop));

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Request / sequencing FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_tape_addr <= '0;
            r_remaining <= '0;
            // The responder's ack level survives our reset; adopt it so no
            // phantom completion is seen afterwards.
            r_ack_seen  <= tape_rd_ack;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    // Nothing is outstanding here, so any ack movement
                    // (e.g. a late ack from before a reset) is absorbed.
                    r_ack_seen <= tape_rd_ack;
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (start) begin
                        r_tape_addr <= start_addr;
                        r_remaining <= tape_len;
                        r_state     <= (tape_len == '0) ? c_ST_DONE : c_ST_REQ;
                    end else if (r_state == c_ST_DONE) begin
                        r_done <= (w_count_nxt == '0);
                    end
                end

                c_ST_REQ: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_can_req) begin
                        // tape_rd is asserted combinationally in this cycle.
                        r_state <= c_ST_WAIT;
                    end
                end

                c_ST_WAIT: begin
                    if (w_ack) begin
                        r_ack_seen <= tape_rd_ack;
                        if (stop) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_tape_addr <= r_tape_addr + ADDR_W'(1);
                            r_remaining <= r_remaining - ADDR_W'(1);
                            r_state     <= (r_remaining == ADDR_W'(1)) ?
                                           c_ST_DONE : c_ST_REQ;
                        end
                    end else if (stop) begin
                        // The read is still in flight; its ack must be
                        // consumed before a new request may be issued.
                        r_state <= c_ST_ABORT;
                    end
                end

                c_ST_ABORT: begin
                    if (w_ack) begin
                        r_ack_seen <= tape_rd_ack;
                        r_state    <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tape_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_head_from_input) begin
                r_head <= tape_dout;
            end else begin
                r_head <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Gated by stop/reset so an aborting cycle never launches a request.
    assign tape_rd    = (r_state == c_ST_REQ) && w_can_req && !stop && !reset;
    assign tape_addr  = r_tape_addr;
    assign byte_data  = r_head;
    assign byte_valid = (r_count != '0);
    assign fifo_level = r_count;
    assign busy       = (r_state == c_ST_REQ) || (r_state == c_ST_WAIT) ||
                        (r_state == c_ST_ABORT);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tape_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tape_stream_reader
// Description : Directed self-checking bench for tape_stream_reader with a
//               toggle-ack SDRAM responder model and a byte sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_stream_reader;

    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 23;

    logic              clk         = 1'b0;
    logic              reset       = 1'b1;
    logic              start       = 1'b0;
    logic              stop        = 1'b0;
    logic [ADDR_W-1:0] start_addr  = '0;
    logic [ADDR_W-1:0] tape_len    = '0;
    logic [ADDR_W-1:0] tape_addr;
    logic              tape_rd;
    logic [7:0]        tape_dout   = 8'h00;
    logic              tape_rd_ack = 1'b1;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready  = 1'b0;
    logic              busy;
    logic              done;
    logic [3:0]        fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    int                resp_delay = 0;
    logic              resp_pend  = 1'b0;
    int                resp_cnt   = 0;
    logic [ADDR_W-1:0] resp_addr  = '0;

    logic [ADDR_W-1:0] req_q [$];
    logic [7:0]        rx_q  [$];

    tape_stream_reader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .start_addr  (start_addr),
        .tape_len    (tape_len),
        .tape_addr   (tape_addr),
        .tape_rd     (tape_rd),
        .tape_dout   (tape_dout),
        .tape_rd_ack (tape_rd_ack),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .busy        (busy),
        .done        (done),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // SDRAM contents seen by the responder.
    function automatic logic [7:0] ram_rd(input logic [ADDR_W-1:0] a);
        case (a)
            23'h000100: return 8'h11;
            23'h000101: return 8'h22;
            23'h000102: return 8'h33;
            23'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h3C;
        endcase
    endfunction

    // Responder: ack toggles resp_delay edges after the request edge.
    always @(posedge clk) begin
        if (resp_pend) begin
            if (resp_cnt <= 1) begin
                tape_rd_ack <= ~tape_rd_ack;
                tape_dout   <= ram_rd(resp_addr);
                resp_pend   <= 1'b0;
            end else begin
                resp_cnt <= resp_cnt - 1;
            end
        end
        if (tape_rd) begin
            check("one_outstanding", {31'd0, resp_pend}, 32'd0);
            req_q.push_back(tape_addr);
            if (resp_delay == 0) begin
                tape_rd_ack <= ~tape_rd_ack;
                tape_dout   <= ram_rd(tape_addr);
            end else begin
                resp_pend <= 1'b1;
                resp_cnt  <= resp_delay;
                resp_addr <= tape_addr;
            end
        end
    end

    // Byte sink.
    always @(posedge clk) begin
        if (!reset && byte_valid && byte_ready) begin
            rx_q.push_back(byte_data);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge of the cycle after start was high.
    task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l);
        start_addr = a;
        tape_len   = l;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic check_stream(input logic [ADDR_W-1:0] base, input int len);
        logic [ADDR_W-1:0] a;
        check("req_count", req_q.size(), len);
        check("byte_count", rx_q.size(), len);
        for (int i = 0; i < len; i++) begin
            a = base + ADDR_W'(i);
            if (i < req_q.size()) check("req_addr", {9'd0, req_q[i]}, {9'd0, a});
            if (i < rx_q.size())  check("byte_val", {24'd0, rx_q[i]}, {24'd0, ram_rd(a)});
        end
    endtask

    task automatic clear_q();
        req_q.delete();
        rx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // ---------------- reset ----------------
        cyc(3);
        check("rst_tape_rd",   {31'd0, tape_rd}, 32'd0);
        check("rst_tape_addr", {9'd0, tape_addr}, 32'd0);
        check("rst_valid",     {31'd0, byte_valid}, 32'd0);
        check("rst_data",      {24'd0, byte_data}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_done",      {31'd0, done}, 32'd0);
        check("rst_level",     {28'd0, fifo_level}, 32'd0);
        reset = 1'b0;
        cyc(2);

        // ---------------- T1: basic 4-byte fetch, latency ----------------
        byte_ready = 1'b1;
        clear_q();
        pulse_start(23'h000100, 23'd4);
        check("t1_rd_n1",   {31'd0, tape_rd}, 32'd1);
        check("t1_addr_n1", {9'd0, tape_addr}, 32'h100);
        check("t1_busy_n1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_valid_n2", {31'd0, byte_valid}, 32'd0);
        @(negedge clk);
        check("t1_valid_n3", {31'd0, byte_valid}, 32'd1);
        check("t1_data_n3",  {24'd0, byte_data}, 32'h11);
        wait_done(40);
        cyc(4);
        check_stream(23'h000100, 4);
        check("t1_busy_end",  {31'd0, busy}, 32'd0);
        check("t1_level_end", {28'd0, fifo_level}, 32'd0);

        // ---------------- T2: backpressure, FIFO full ----------------
        byte_ready = 1'b0;
        clear_q();
        pulse_start(23'h000200, 23'd12);
        cyc(40);
        check("t2_reqs_full",  req_q.size(), 8);
        check("t2_level_full", {28'd0, fifo_level}, 32'd8);
        check("t2_rd_held",    {31'd0, tape_rd}, 32'd0);
        check("t2_busy_full",  {31'd0, busy}, 32'd1);
        check("t2_head",       {24'd0, byte_data}, {24'd0, ram_rd(23'h000200)});
        byte_ready = 1'b1;
        wait_done(80);
        cyc(2);
        check_stream(23'h000200, 12);

        // ---------------- T3: address wrap ----------------
        clear_q();
        pulse_start(23'h7FFFFE, 23'd4);
        wait_done(40);
        cyc(2);
        check_stream(23'h7FFFFE, 4);
        if (req_q.size() == 4) begin
            check("t3_wrap_2", {9'd0, req_q[2]}, 32'h0);
            check("t3_wrap_3", {9'd0, req_q[3]}, 32'h1);
        end

        // ---------------- T4: stop during WAIT, slow ack ----------------
        byte_ready = 1'b0;
        resp_delay = 0;
        clear_q();
        pulse_start(23'h000300, 23'd4);
        k = 0;
        while (fifo_level != 4'd1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t4_first_push", {28'd0, fifo_level}, 32'd1);
        check("t4_second_rd",  {31'd0, tape_rd}, 32'd1);
        resp_delay = 5;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4_flushed",   {28'd0, fifo_level}, 32'd0);
        check("t4_valid_low", {31'd0, byte_valid}, 32'd0);
        check("t4_abort_busy",{31'd0, busy}, 32'd1);
        check("t4_ack_pend",  {31'd0, resp_pend}, 32'd1);
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t4_abort_cycles", k, 5);
        check("t4_ack_taken",    {31'd0, resp_pend}, 32'd0);
        check("t4_no_stale",     {28'd0, fifo_level}, 32'd0);
        check("t4_reqs",         req_q.size(), 2);
        resp_delay = 0;
        byte_ready = 1'b1;
        clear_q();
        pulse_start(23'h000100, 23'd2);
        wait_done(30);
        cyc(2);
        check_stream(23'h000100, 2);

        // ---------------- T5: zero length ----------------
        clear_q();
        pulse_start(23'h000500, 23'd0);
        check("t5_done_n1", {31'd0, done}, 32'd0);
        check("t5_rd_n1",   {31'd0, tape_rd}, 32'd0);
        check("t5_busy_n1", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t5_done_n2", {31'd0, done}, 32'd1);
        cyc(3);
        check("t5_valid", {31'd0, byte_valid}, 32'd0);
        check("t5_reqs",  req_q.size(), 0);

        // ---------------- T6: reset mid-transfer, late ack ----------------
        resp_delay = 3;
        clear_q();
        pulse_start(23'h000400, 23'd8);
        check("t6_rd", {31'd0, tape_rd}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_busy",  {31'd0, busy}, 32'd0);
        check("t6_rst_level", {28'd0, fifo_level}, 32'd0);
        check("t6_rst_addr",  {9'd0, tape_addr}, 32'd0);
        check("t6_late_pend", {31'd0, resp_pend}, 32'd1);
        cyc(6);
        check("t6_late_done", {31'd0, resp_pend}, 32'd0);
        check("t6_no_push",   {28'd0, fifo_level}, 32'd0);
        check("t6_no_valid",  {31'd0, byte_valid}, 32'd0);
        resp_delay = 0;
        clear_q();
        pulse_start(23'h000100, 23'd2);
        wait_done(30);
        cyc(3);
        check_stream(23'h000100, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
